adc_capture_ctrl: RTL and testbench

- Sequences the ADC sample FIFO in the adc_sampleclk domain.
- Generates the FIFO arm level and capture_go from the software arm request and the trigger, and waits for the FIFO's capture_stop.
- Supports multi-segment capture with inter-segment holdoff, and an auto-trigger timeout.
- Sits between the register block and the capture FIFO.

---
 rtl/adc_capture_ctrl_pkg.sv | 17 +
 rtl/adc_capture_ctrl_if.sv | 36 +++
 rtl/adc_capture_ctrl_edge_det.sv | 19 +
 rtl/adc_capture_ctrl.sv | 166 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture sequencer: the state encoding (also used
// by the register readback decode) and the default arm settle time.
package capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMING  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_DONE    = 3'd5
  } cap_state_e;

  // Must stay >= 3 so the FIFO arm-edge reset pipeline has cleared before a trigger.
  localparam int ARM_SETTLE_DEF = 4;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Control/status bundle between the register block, the capture sequencer and the
// sample FIFO; master is the sequencer side.
interface adc_capture_ctrl_if #(
  parameter int SEG_W     = 16,
  parameter int HOLDOFF_W = 16,
  parameter int TIMEOUT_W = 32
);
  logic                 arm_i;
  logic                 trigger_i;
  logic                 stream_mode_i;
  logic                 capture_stop_i;
  logic [SEG_W-1:0]     num_segments_i;
  logic [HOLDOFF_W-1:0] seg_holdoff_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic                 fifo_arm_o;
  logic                 capture_go_o;
  logic                 armed_o;
  logic                 done_o;
  logic [SEG_W-1:0]     seg_index_o;
  logic                 timed_out_o;
  logic [2:0]           state_o;

  modport master (
    input  arm_i, trigger_i, stream_mode_i, capture_stop_i,
           num_segments_i, seg_holdoff_i, timeout_i,
    output fifo_arm_o, capture_go_o, armed_o, done_o,
           seg_index_o, timed_out_o, state_o
  );

  modport slave (
    output arm_i, trigger_i, stream_mode_i, capture_stop_i,
           num_segments_i, seg_holdoff_i, timeout_i,
    input  fifo_arm_o, capture_go_o, armed_o, done_o,
           seg_index_o, timed_out_o, state_o
  );
endinterface

// File: rtl/adc_capture_ctrl_edge_det.sv
// Registered edge detector: one-cycle delayed copy of a level, with combinational
// rise/fall pulses relative to that copy.
module capture_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise,
  output logic fall
);
  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;
endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arms the sample FIFO, gates capture on trigger and walks
// multi-segment captures with holdoff. Forced trigger built under ADC_CAPTURE_CTRL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | disarmed, waiting for arm rise
// ARMING  | FIFO arm asserted, settle timer running, triggers discarded
// ARMED   | waiting for trigger (or timeout)
// CAPTURE | capture_go high until FIFO stop
// HOLDOFF | gap between segments, triggers ignored
// DONE    | all segments captured, waiting for arm fall
module adc_capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int SEG_W      = 16,
  parameter int HOLDOFF_W  = 16,
  parameter int TIMEOUT_W  = 32,
  parameter int ARM_SETTLE = ARM_SETTLE_DEF
) (
  input logic                adc_sampleclk,
  input logic                reset_n,
  adc_capture_ctrl_if.master bus
);

  localparam logic [HOLDOFF_W-1:0] SETTLE_LOAD = HOLDOFF_W'(ARM_SETTLE - 1);

  cap_state_e           state;
  logic [HOLDOFF_W-1:0] cnt;
  logic                 fifo_arm;
  logic                 capture_go;
  logic                 armed;
  logic                 done;
  logic                 timed_out;
  logic [SEG_W-1:0]     seg_index;
  logic [SEG_W-1:0]     seg_next;
  logic [SEG_W-1:0]     num_eff;
  logic                 arm_rise;
  logic                 arm_fall;
  logic                 trig_ev;
  logic                 unused_trig_fall;
  logic                 tmo_hit;

  capture_edge_det u_arm_edge (
    .clk   (adc_sampleclk),
    .rst_n (reset_n),
    .level (bus.arm_i),
    .rise  (arm_rise),
    .fall  (arm_fall)
  );

  capture_edge_det u_trig_edge (
    .clk   (adc_sampleclk),
    .rst_n (reset_n),
    .level (bus.trigger_i),
    .rise  (trig_ev),
    .fall  (unused_trig_fall)
  );

  assign seg_next = (&seg_index) ? seg_index : seg_index + SEG_W'(1);
  assign num_eff  = (bus.num_segments_i == '0) ? SEG_W'(1) : bus.num_segments_i;

`ifdef ADC_CAPTURE_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Held at zero outside ARMED, so every ARMED entry starts a fresh count.
  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n)                tmo_cnt <= '0;
    else if (state != ST_ARMED)  tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
  end

  assign tmo_hit = (state == ST_ARMED) && (bus.timeout_i != '0) &&
                   (tmo_cnt == bus.timeout_i - TIMEOUT_W'(1));
`else
  logic unused_timeout;
  assign unused_timeout = ^bus.timeout_i;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      fifo_arm   <= 1'b0;
      capture_go <= 1'b0;
      armed      <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
      seg_index  <= '0;
    end else if (arm_fall && (state != ST_IDLE)) begin
      // Abort wins over stop, trigger and timeout; index and timeout flag are kept for readback.
      state      <= ST_IDLE;
      fifo_arm   <= 1'b0;
      capture_go <= 1'b0;
      armed      <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm_rise) begin
            state     <= ST_ARMING;
            fifo_arm  <= 1'b1;
            seg_index <= '0;
            timed_out <= 1'b0;
            cnt       <= SETTLE_LOAD;
          end
        end
        ST_ARMING: begin
          if (cnt == '0) begin
            state <= ST_ARMED;
            armed <= 1'b1;
          end else begin
            cnt <= cnt - HOLDOFF_W'(1);
          end
        end
        ST_ARMED: begin
          if (trig_ev || tmo_hit) begin
            state      <= ST_CAPTURE;
            armed      <= 1'b0;
            capture_go <= 1'b1;
            timed_out  <= ~trig_ev;
          end
        end
        ST_CAPTURE: begin
          if (bus.capture_stop_i) begin
            capture_go <= 1'b0;
            seg_index  <= seg_next;
            if ((seg_next >= num_eff) || bus.stream_mode_i) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_HOLDOFF;
              cnt   <= bus.seg_holdoff_i;
            end
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0) begin
            state <= ST_ARMED;
            armed <= 1'b1;
          end else begin
            cnt <= cnt - HOLDOFF_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state      <= ST_IDLE;
          fifo_arm   <= 1'b0;
          capture_go <= 1'b0;
          armed      <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_arm_o   = fifo_arm;
  assign bus.capture_go_o = capture_go;
  assign bus.armed_o      = armed;
  assign bus.done_o       = done;
  assign bus.seg_index_o  = seg_index;
  assign bus.timed_out_o  = timed_out;
  assign bus.state_o      = state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus queues the expected state
// transitions (outputs snapshot + cycles spent in the previous state); a monitor pops on each change.
module tb_adc_capture_ctrl;
  import capture_ctrl_pkg::*;

  localparam int SEG_W     = 16;
  localparam int HOLDOFF_W = 16;
  localparam int TIMEOUT_W = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  adc_capture_ctrl_if #(.SEG_W(SEG_W), .HOLDOFF_W(HOLDOFF_W), .TIMEOUT_W(TIMEOUT_W)) bus ();

  adc_capture_ctrl #(
    .SEG_W      (SEG_W),
    .HOLDOFF_W  (HOLDOFF_W),
    .TIMEOUT_W  (TIMEOUT_W),
    .ARM_SETTLE (4)
  ) dut (
    .adc_sampleclk (clk),
    .reset_n       (reset_n),
    .bus           (bus)
  );

  typedef struct packed {
    logic [23:0] snap;
    int          dwell;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] snap_dut();
    return {bus.state_o, bus.fifo_arm_o, bus.capture_go_o, bus.armed_o, bus.done_o,
            bus.seg_index_o, bus.timed_out_o};
  endfunction

  // Output levels per state: arm is high everywhere but IDLE, the others mark one state each.
  function automatic logic [23:0] mk(input cap_state_e st, input logic [15:0] seg, input logic tmo);
    logic fa, go, ar, dn;
    fa = (st != ST_IDLE);
    go = (st == ST_CAPTURE);
    ar = (st == ST_ARMED);
    dn = (st == ST_DONE);
    return {st, fa, go, ar, dn, seg, tmo};
  endfunction

  task automatic push_exp(input cap_state_e st, input logic [15:0] seg, input logic tmo,
                          input int dwell);
    exp_t e;
    e.snap  = mk(st, seg, tmo);
    e.dwell = dwell;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    bus.trigger_i = 1'b1;
    tick(1);
    bus.trigger_i = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.capture_stop_i = 1'b1;
    tick(1);
    bus.capture_stop_i = 1'b0;
  endtask

  // Rise of arm; returns one cycle into ARMED (ARMING lasts ARM_SETTLE=4 cycles).
  task automatic arm_up(input bit trig_in_arming);
    push_exp(ST_ARMING, 16'd0, 1'b0, -1);
    push_exp(ST_ARMED, 16'd0, 1'b0, 4);
    bus.arm_i = 1'b1;
    if (trig_in_arming) begin
      tick(2);
      pulse_trig();
      tick(2);
    end else begin
      tick(5);
    end
  endtask

  task automatic arm_down(input logic [15:0] seg, input logic tmo);
    push_exp(ST_IDLE, seg, tmo, -1);
    bus.arm_i = 1'b0;
    tick(2);
  endtask

  // Monitor: every change of state_o must match the next queued expectation.
  initial begin : monitor
    logic [2:0] prev_st;
    int         last_cyc;
    int         n;
    exp_t       e;
    prev_st  = 3'd0;
    last_cyc = 0;
    n        = 0;
    forever begin
      @(negedge clk);
      if (bus.state_o !== prev_st) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transition actual_state=%0d from_state=%0d", bus.state_o, prev_st);
        end else begin
          e = q.pop_front();
          check($sformatf("trans%0d_outputs", n), 32'(snap_dut()), 32'(e.snap));
          if (e.dwell >= 0)
            check($sformatf("trans%0d_dwell", n), 32'(cyc - last_cyc), 32'(e.dwell));
        end
        n++;
        prev_st  = bus.state_o;
        last_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    bus.arm_i          = 1'b0;
    bus.trigger_i      = 1'b0;
    bus.stream_mode_i  = 1'b0;
    bus.capture_stop_i = 1'b0;
    bus.num_segments_i = 16'd1;
    bus.seg_holdoff_i  = 16'd0;
    bus.timeout_i      = 32'd0;

    #1;
    check("reset_outputs", 32'(snap_dut()), 32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("post_reset_idle", 32'(snap_dut()), 32'd0);

    // Single shot: trigger 10 cycles after arm rise, stop 50 cycles after trigger.
    bus.num_segments_i = 16'd1;
    arm_up(1'b0);
    push_exp(ST_CAPTURE, 16'd0, 1'b0, 6);
    tick(5);
    pulse_trig();
    push_exp(ST_DONE, 16'd1, 1'b0, 50);
    tick(49);
    pulse_stop();
    tick(3);
    arm_down(16'd1, 1'b0);

    // Three segments, holdoff 5 (6 cycles in HOLDOFF), stray trigger inside holdoff.
    bus.num_segments_i = 16'd3;
    bus.seg_holdoff_i  = 16'd5;
    arm_up(1'b0);
    for (int i = 0; i < 3; i++) begin
      push_exp(ST_CAPTURE, 16'(i), 1'b0, 1);
      pulse_trig();
      if (i < 2) begin
        push_exp(ST_HOLDOFF, 16'(i + 1), 1'b0, 4);
        push_exp(ST_ARMED, 16'(i + 1), 1'b0, 6);
      end else begin
        push_exp(ST_DONE, 16'd3, 1'b0, 4);
      end
      tick(3);
      pulse_stop();
      if (i < 2) begin
        tick(1);
        pulse_trig();
        tick(4);
      end
    end
    tick(2);
    arm_down(16'd3, 1'b0);

    // Holdoff 0 spends exactly one cycle in HOLDOFF.
    bus.num_segments_i = 16'd2;
    bus.seg_holdoff_i  = 16'd0;
    arm_up(1'b0);
    push_exp(ST_CAPTURE, 16'd0, 1'b0, 1);
    pulse_trig();
    push_exp(ST_HOLDOFF, 16'd1, 1'b0, 2);
    push_exp(ST_ARMED, 16'd1, 1'b0, 1);
    tick(1);
    pulse_stop();
    tick(1);
    push_exp(ST_CAPTURE, 16'd1, 1'b0, 1);
    pulse_trig();
    push_exp(ST_DONE, 16'd2, 1'b0, 2);
    tick(1);
    pulse_stop();
    tick(2);
    arm_down(16'd2, 1'b0);

    // num_segments 0 behaves as 1.
    bus.num_segments_i = 16'd0;
    arm_up(1'b0);
    push_exp(ST_CAPTURE, 16'd0, 1'b0, 1);
    pulse_trig();
    push_exp(ST_DONE, 16'd1, 1'b0, 3);
    tick(2);
    pulse_stop();
    tick(2);
    arm_down(16'd1, 1'b0);

    // Stream mode: first stop goes straight to DONE; trigger during ARMING is discarded.
    bus.stream_mode_i  = 1'b1;
    bus.num_segments_i = 16'd4;
    arm_up(1'b1);
    push_exp(ST_CAPTURE, 16'd0, 1'b0, 1);
    pulse_trig();
    push_exp(ST_DONE, 16'd1, 1'b0, 4);
    tick(3);
    pulse_stop();
    tick(2);
    arm_down(16'd1, 1'b0);
    bus.stream_mode_i = 1'b0;

    // Abort: arm fall coincident with stop wins; index unchanged.
    bus.num_segments_i = 16'd2;
    arm_up(1'b0);
    push_exp(ST_CAPTURE, 16'd0, 1'b0, 1);
    pulse_trig();
    push_exp(ST_IDLE, 16'd0, 1'b0, 4);
    tick(3);
    bus.arm_i          = 1'b0;
    bus.capture_stop_i = 1'b1;
    tick(1);
    bus.capture_stop_i = 1'b0;
    tick(2);

    // No trigger and no usable timeout: ARMED holds.
`ifdef ADC_CAPTURE_CTRL_TIMEOUT_EN
    bus.timeout_i = 32'd0;
`else
    bus.timeout_i = 32'd100;
`endif
    bus.num_segments_i = 16'd1;
    arm_up(1'b0);
    tick(250);
    check("armed_holds_no_trigger", 32'(bus.state_o), 32'(ST_ARMED));
    arm_down(16'd0, 1'b0);

`ifdef ADC_CAPTURE_CTRL_TIMEOUT_EN
    // Forced trigger exactly 100 cycles after ARMED entry.
    bus.timeout_i = 32'd100;
    arm_up(1'b0);
    push_exp(ST_CAPTURE, 16'd0, 1'b1, 100);
    push_exp(ST_DONE, 16'd1, 1'b1, -1);
    tick(110);
    pulse_stop();
    tick(2);
    arm_down(16'd1, 1'b1);
    // Real trigger on the timeout cycle leaves timed_out clear.
    arm_up(1'b0);
    push_exp(ST_CAPTURE, 16'd0, 1'b0, 100);
    tick(99);
    pulse_trig();
    push_exp(ST_DONE, 16'd1, 1'b0, -1);
    tick(2);
    pulse_stop();
    tick(2);
    arm_down(16'd1, 1'b0);
    bus.timeout_i = 32'd0;
`endif

    // Async reset in the second segment's CAPTURE clears everything without a clock.
    bus.num_segments_i = 16'd2;
    bus.seg_holdoff_i  = 16'd0;
    arm_up(1'b0);
    push_exp(ST_CAPTURE, 16'd0, 1'b0, 1);
    pulse_trig();
    push_exp(ST_HOLDOFF, 16'd1, 1'b0, 2);
    push_exp(ST_ARMED, 16'd1, 1'b0, 1);
    tick(1);
    pulse_stop();
    tick(1);
    push_exp(ST_CAPTURE, 16'd1, 1'b0, 1);
    pulse_trig();
    tick(3);
    push_exp(ST_IDLE, 16'd0, 1'b0, -1);
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    bus.arm_i = 1'b0;
    #1;
    check("async_reset_outputs", 32'(snap_dut()), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
